// File: rtl/ofifo_pkg.sv
// Shared defaults, pointer-width helper and error-flag type for the ofifo_align output FIFO.
package ofifo_pkg;

  localparam int unsigned default_bw    = 16;
  localparam int unsigned default_col   = 8;
  localparam int unsigned default_depth = 64;

  typedef struct packed {
    logic ovf;
    logic udf;
  } err_t;

  // Index bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane circular FIFO: storage, wrap-bit pointers, combinational head.
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int unsigned bw    = default_bw,
  parameter int unsigned depth = default_depth
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd_en,
  input  logic [bw-1:0] din,
  output logic [bw-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  localparam int unsigned pw = ptr_w(depth);
  localparam int unsigned aw = pw - 1;

  logic [pw-1:0] wptr;
  logic [pw-1:0] rptr;
  logic [bw-1:0] mem [depth];
  logic          wr_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
  assign wr_ok = wr & ~full;
  assign ovf   = wr & full;
  assign dout  = mem[rptr[aw-1:0]];

  // rd_en is already qualified by the top, so a read here never hits an empty lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + pw'(1);
      if (rd_en) rptr <= rptr + pw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[aw-1:0]] <= din;
  end

endmodule

// File: rtl/ofifo_align.sv
// Per-column output FIFO releasing aligned psum rows to sfp; sticky error flags
// on o_err exist only when OFIFO_ERR_EN is defined.
module ofifo_align
  import ofifo_pkg::*;
#(
  parameter int unsigned bw    = default_bw,
  parameter int unsigned col   = default_col,
  parameter int unsigned depth = default_depth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col-1:0]    wr,
  input  logic [bw*col-1:0] in,
  input  logic              rd,
  output logic [bw*col-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready
`ifdef OFIFO_ERR_EN
  ,
  output err_t              o_err
`endif
);

  logic [col-1:0]    lane_empty;
  logic [col-1:0]    lane_full;
  logic [col-1:0]    lane_ovf;
  logic [bw*col-1:0] heads;
  logic              rd_en;

  for (genvar i = 0; i < col; i++) begin : g_lane
    ofifo_lane #(
      .bw   (bw),
      .depth(depth)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[i]),
      .rd_en(rd_en),
      .din  (in[bw*i +: bw]),
      .dout (heads[bw*i +: bw]),
      .empty(lane_empty[i]),
      .full (lane_full[i]),
      .ovf  (lane_ovf[i])
    );
  end

  // Status comes from pointer state only, never from wr/rd.
  assign o_valid = ~|lane_empty;
  assign o_full  = |lane_full;
  assign o_ready = ~o_full;
  assign rd_en   = rd & o_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      out <= '0;
    else if (rd_en) out <= heads;
  end

`ifdef OFIFO_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_err <= '0;
    end else begin
      if (|lane_ovf)       o_err.ovf <= 1'b1;
      if (rd && !o_valid)  o_err.udf <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/ofifo_align.md
# ofifo_align

Per-column output FIFO between the MAC array and the `sfp` accumulation/ReLU stage. Each of `col` lanes captures psums from its array column independently, because columns retire with skew. The block releases one aligned row of `col` psums only when every lane holds data. The registered row output drives `sfp.in` directly.

## Interface
- `bw`, 16, psum width per column
- `col`, 8, number of columns/lanes
- `depth`, 64, entries per lane; power of two, ≥ 2
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `wr`  in  col  per-lane write enable; bit i writes `in[bw*(i+1)-1:bw*i]`
- `in`  in  bw*col  psums from array columns
- `rd`  in  1  pop one aligned row
- `out`  out  bw*col  registered popped row, to `sfp.in`
- `o_valid`  out  1  every lane non-empty
- `o_full`  out  1  any lane full
- `o_ready`  out  1  no lane full (= ~`o_full`)
- `o_err`  out  2  {overflow, underflow} sticky flags, only with `OFIFO_ERR_EN`

## Operation
- Each lane is a circular buffer with a write pointer and a read pointer. Each pointer is `$clog2(depth)+1` bits. The MSB is the wrap bit.
- Lane empty: pointers are fully equal.
- Lane full: index bits are equal and wrap bits differ.
- Write, lane i: accepted when `wr[i]` is high and lane i is not full. The data is stored at `wptr[i]` and `wptr[i]` increments. A write to a full lane is dropped and leaves no other state change.
- Read: accepted when `rd` is high and `o_valid` is high. Every lane's head moves to `out` and every `rptr` increments together.
- `rd` while `o_valid` is low is ignored. `out` holds its value.
- Full and empty are evaluated on the pre-edge pointers:
  - A read and a write on a full lane in the same cycle: the read succeeds and the write is dropped.
  - A read and a write on a lane that is empty while other lanes are not: the read is ignored (`o_valid` is low) and the write succeeds.
- Lanes operate independently for writes. Reads are always lock-step across all lanes.
- Data passes through unmodified. There is no arithmetic and no sign handling.

## Timing
- Reset: all pointers 0, `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `o_err`=0.
- Write accepted at edge k: the lane is counted non-empty after edge k. `o_valid` can rise in the cycle after edge k.
- `o_valid`, `o_full`, `o_ready` are combinational from the pointer registers only. They do not depend combinationally on `wr` or `rd`.
- Read latency is 1 cycle. With `rd` and `o_valid` high at edge k, `out` presents the row after edge k.
- Back-to-back reads give one row per cycle while `o_valid` stays high.
- Wrap-around: pointers roll over silently. Full and empty stay correct across any number of wraps.
- Reset mid-operation discards all content immediately. It does not wait for a clock.

## Configuration
- Macro: `OFIFO_ERR_EN`.
- Defined:
  - `o_err[1]` sets on any dropped write (any lane).
  - `o_err[0]` sets on `rd` while `o_valid` is low.
  - Both flags are sticky until `reset`.
- Undefined: the `o_err` port is absent and there is no flag logic. Dropped writes and ignored reads still behave as described in Operation.

## Structure
- Shared package `ofifo_pkg`: the default `bw`, `col` and `depth` constants, the pointer-width function and an `err_t` typedef (2-bit {ovf, udf}).
- Sub-module `ofifo_lane`: single-lane FIFO with storage and pointers.
  - Inputs: `wr`, `rd_en`, `din`.
  - Outputs: `dout` (combinational head), `empty`, `full`, `ovf`.
  - The top instantiates `col` lanes. It registers the concatenated heads into `out`, ANDs the `~empty` signals into `o_valid` and ORs the `full` signals into `o_full`.

## Test plan
- Reset, then write `wr`=8'hFF with lane i = 16'h0100+i, then `rd` → `o_valid`=1 one cycle after the write; `out` = {16'h0107,…,16'h0100} one cycle after `rd`; `o_valid`=0 afterwards.
- Skewed writes: lane i written at cycle i, i=0..7 → `o_valid` stays 0 until one cycle after the lane-7 write; `rd` pulsed earlier has no effect and sets `o_err[0]` when `OFIFO_ERR_EN` is defined.
- Fill all lanes with 64 entries (values 0..63) → `o_full`=1, `o_ready`=0. A 65th write is dropped and sets `o_err[1]`. 64 reads return rows 0..63 in order.
- Lane 0 full, same-cycle `rd` plus `wr[0]` → read returns the lane-0 head and the write is dropped. Lane 0 occupancy becomes 63.
- Wrap: 200 rows streamed with interleaved writes and reads, never more than 10 entries deep → all 200 rows are returned in order with no loss.
- Assert `reset` asynchronously mid-stream with 5 rows queued → `out`=0 and `o_valid`=0 before the next edge. The following write/read returns only new data.
